// File: rtl/resp_encode.sv
// resp_encode: frames SDRAM read-back bytes from rfifo into UART response packets
// (HDR, LEN, BURST_LEN payload bytes, CSUM) and hands them to uart_tx one byte at a time.
module resp_encode #(
    parameter int                 D_WIDTH   = 8,
    parameter int                 BURST_LEN = 4,
    parameter logic [D_WIDTH-1:0] HDR_BYTE  = 8'hA5,
    parameter int                 PEND_MAX  = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               rd_done,
    input  logic               rfifo_empty,
    input  logic [D_WIDTH-1:0] rfifo_rd_data,
    output logic               rfifo_rd_en,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [D_WIDTH-1:0] tx_data,
    output logic               busy,
    output logic               pend_ovf
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] LEN   = 3'd2;
    localparam logic [2:0] FETCH = 3'd3;
    localparam logic [2:0] LOAD  = 3'd4;
    localparam logic [2:0] SEND  = 3'd5;
    localparam logic [2:0] CSUM  = 3'd6;

    logic [2:0]         state;
    logic [1:0]         pend;
    logic [7:0]         cnt;
    logic [D_WIDTH-1:0] csum;
    logic [D_WIDTH-1:0] csum_sum;
    logic               xfer;
    logic               start;
    logic               last;

    assign xfer        = tx_valid && tx_ready;
    assign start       = (state == IDLE) && (pend != 2'd0);
    assign last        = cnt == 8'(BURST_LEN - 1);
    assign csum_sum    = csum + tx_data;
    // read strobe is gated by empty so the FIFO can never underflow
    assign rfifo_rd_en = (state == FETCH) && !rfifo_empty;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend     <= 2'd0;
            pend_ovf <= 1'b0;
        end else if (rd_done && !start) begin
            if (pend == 2'(PEND_MAX)) pend_ovf <= 1'b1;
            else pend <= pend + 2'd1;
        end else if (start && !rd_done) begin
            pend <= pend - 2'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            csum     <= '0;
            cnt      <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= HDR;
                    busy     <= 1'b1;
                    tx_data  <= HDR_BYTE;
                    tx_valid <= 1'b1;
                    csum     <= '0;
                    cnt      <= 8'd0;
                end
                HDR: if (xfer) begin
                    state   <= LEN;
                    tx_data <= D_WIDTH'(BURST_LEN);
                    csum    <= D_WIDTH'(BURST_LEN);
                end
                LEN: if (xfer) begin
                    state    <= FETCH;
                    tx_valid <= 1'b0;
                end
                FETCH: if (!rfifo_empty) state <= LOAD;
                LOAD: begin
                    state    <= SEND;
                    tx_data  <= rfifo_rd_data;
                    tx_valid <= 1'b1;
                end
                SEND: if (xfer) begin
                    csum <= csum_sum;
                    if (last) begin
                        state   <= CSUM;
                        tx_data <= csum_sum;
                    end else begin
                        cnt      <= cnt + 8'd1;
                        state    <= FETCH;
                        tx_valid <= 1'b0;
                    end
                end
                CSUM: if (xfer) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_resp_encode.sv
// tb_resp_encode: table-driven frames plus hand sequences for stalls, pending queue and reset,
// with a byte scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_resp_encode;
    logic       sys_clk = 0, sys_rst = 0, rd_done = 0, tx_ready = 1;
    logic       rfifo_empty, rfifo_rd_en, tx_valid, busy, pend_ovf;
    logic [7:0] rfifo_rd_data = 8'h00, tx_data;

    resp_encode dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_done(rd_done),
        .rfifo_empty(rfifo_empty), .rfifo_rd_data(rfifo_rd_data), .rfifo_rd_en(rfifo_rd_en),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .busy(busy), .pend_ovf(pend_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO model: data appears the cycle after the read strobe; reset discards unread bytes
    logic [7:0] mem [256];
    logic [7:0] wp = 8'd0, rp = 8'd0;
    logic       hold_empty = 0;
    assign rfifo_empty = hold_empty || (wp == rp);
    always @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) rp <= wp;
        else if (rfifo_rd_en) begin
            rfifo_rd_data <= mem[rp];
            rp <= rp + 8'd1;
        end

    int         asserts = 0, fails = 0, pos = 0, rd_cnt = 0, cyc = 0;
    logic [7:0] exp_q[$];
    bit         seen_idle = 1, prev_stall = 0, ready_mode = 0;
    logic [7:0] prev_data;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    initial forever begin
        @(posedge sys_clk);
        #1 cyc++;
        tx_ready = ready_mode ? (cyc % 3 == 0) : 1'b1;
    end

    always @(negedge sys_clk) if (!sys_rst) begin
        if (prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
        end
        if (rfifo_rd_en) begin
            rd_cnt++;
            check("rd_en_nonempty", rfifo_empty, 0);
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("unexpected_tx", tx_data, 32'hffff_ffff);
            else begin
                if (pos == 0) begin
                    check("idle_gap", seen_idle, 1);
                    seen_idle = 0;
                end
                check("tx_byte", tx_data, exp_q.pop_front());
                pos = (pos + 1) % 7;
            end
        end
        if (!busy) seen_idle = 1;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_fifo(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 8'd1;
    endtask

    task automatic expect_frame(input logic [3:0][7:0] p, input logic [7:0] cs, input bit fill);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(p[i]);
            if (fill) push_fifo(p[i]);
        end
        exp_q.push_back(cs);
    endtask

    function automatic logic [7:0] model_csum(input logic [3:0][7:0] p);
        logic [7:0] s = 8'h04;
        for (int i = 0; i < 4; i++) s = s + p[i];
        return s;
    endfunction

    task automatic pulse();
        rd_done = 1;
        tick();
        rd_done = 0;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        check("drain", {exp_q.size() == 0, busy}, 2'b10);
    endtask

    task automatic wait_pos(input int target, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (pos == target) break;
            tick();
        end
        check("wait_pos", pos, target);
    endtask

    typedef struct {
        logic [3:0][7:0] pay;
        bit              stall;
        logic [7:0]      csum;
    } vec_t;
    vec_t vt[4];

    initial begin
        int r0;
        logic [3:0][7:0] p;
        vt[0] = '{pay: {8'h44, 8'h33, 8'h22, 8'h11}, stall: 0, csum: 8'hAE};
        vt[1] = '{pay: {8'h44, 8'h33, 8'h22, 8'h11}, stall: 1, csum: 8'hAE};
        vt[2] = '{pay: {8'h04, 8'h03, 8'h02, 8'h01}, stall: 0, csum: 8'h0E};
        vt[3] = '{pay: {8'h01, 8'h7F, 8'h80, 8'h80}, stall: 1, csum: 8'h84};

        #1 sys_rst = 1;
        #2;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rd_en", rfifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pend_ovf", pend_ovf, 0);
        tick(2);
        sys_rst = 0;
        tick(2);

        for (int k = 0; k < 4; k++) begin
            ready_mode = vt[k].stall;
            r0 = rd_cnt;
            expect_frame(vt[k].pay, vt[k].csum, 1);
            pulse();
            drain(300);
            check("rd_en_pulses", rd_cnt - r0, 4);
            check("busy_after", busy, 0);
        end
        ready_mode = 0;

        // all-FF payload with the FIFO starved mid-frame
        expect_frame({4{8'hFF}}, 8'h00, 0);
        push_fifo(8'hFF);
        push_fifo(8'hFF);
        r0 = rd_cnt;
        pulse();
        wait_pos(4, 100);
        hold_empty = 1;
        tick(20);
        check("starve_no_rd", rd_cnt - r0, 2);
        check("starve_busy", busy, 1);
        check("starve_valid", tx_valid, 0);
        push_fifo(8'hFF);
        push_fifo(8'hFF);
        hold_empty = 0;
        drain(200);
        check("starve_rd_total", rd_cnt - r0, 4);

        // rd_done coincident with IDLE->HDR
        check("ovf_clear", pend_ovf, 0);
        p = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
        expect_frame(p, model_csum(p), 1);
        p = {8'hE0, 8'hD0, 8'hC0, 8'hB0};
        expect_frame(p, model_csum(p), 1);
        rd_done = 1;
        tick(2);
        rd_done = 0;
        drain(300);
        tick(10);
        check("no_third_frame", busy, 0);
        check("ovf_still_clear", pend_ovf, 0);

        // pending saturation: 5 rd_done pulses during an active frame
        p = {8'h04, 8'h03, 8'h02, 8'h01};
        expect_frame(p, model_csum(p), 1);
        pulse();
        for (int i = 0; i < 10 && !busy; i++) tick();
        check("sat_busy", busy, 1);
        for (int j = 0; j < 5; j++) begin
            if (j < 3) begin
                p = {8'(j + 8'h40), 8'(j + 8'h30), 8'(j + 8'h20), 8'(j + 8'h10)};
                expect_frame(p, model_csum(p), 1);
            end
            pulse();
            tick();
            check("sat_ovf", pend_ovf, j >= 3);
        end
        drain(800);
        tick(10);
        check("sat_idle", busy, 0);
        check("sat_ovf_sticky", pend_ovf, 1);

        // reset while sending the second payload byte
        p = {8'h99, 8'h88, 8'h77, 8'h66};
        expect_frame(p, model_csum(p), 1);
        pulse();
        wait_pos(3, 100);
        for (int i = 0; i < 10 && !tx_valid; i++) tick();
        check("pre_rst_valid", tx_valid, 1);
        #2 sys_rst = 1;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_rd_en", rfifo_rd_en, 0);
        check("arst_busy", busy, 0);
        check("arst_pend_ovf", pend_ovf, 0);
        exp_q.delete();
        pos = 0;
        seen_idle = 1;
        prev_stall = 0;
        tick(2);
        sys_rst = 0;
        tick(2);
        r0 = rd_cnt;
        p = {8'h5A, 8'h3C, 8'h12, 8'hF0};
        expect_frame(p, model_csum(p), 1);
        pulse();
        drain(200);
        check("post_rst_rd", rd_cnt - r0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
